// File: rtl/memory_writer_pkg.sv
// Shared definitions for the frame capture path (writer and reader).
package memory_writer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int unsigned FRAME_LEN_DEFAULT = 8192;
  localparam int unsigned ADDR_W_DEFAULT    = 13;

endpackage

// File: rtl/memory_writer.sv
// Captures one Avalon-ST frame into memory through an Avalon-MM write master
// and pulses trigger when the frame is complete.
module memory_writer
  import memory_writer_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
  parameter int ADDR_W    = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       memory_writer_sink_data,
  input  logic              memory_writer_sink_valid,
  input  logic              memory_writer_sink_sop,
  input  logic              memory_writer_sink_eop,
  output logic              memory_writer_sink_ready,
  output logic [ADDR_W-1:0] memory_writer_writeaddress,
  output logic              memory_writer_write,
  output logic [31:0]       memory_writer_writedata,
  output logic              memory_writer_trigger,
  output logic              memory_writer_error,
  input  logic              memory_writer_error_clear
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t             state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [CNT_W-1:0]   idx;
  logic [ADDR_W-1:0]  addr_n;
  logic [31:0]        data_n;
  logic               write_n;
  logic               trigger_n;
  logic               err_set;
  logic               accept;
  logic               take;

  // Ready drops only for the single DONE cycle, and during reset.
  assign memory_writer_sink_ready = !rst && (state != DONE);
  assign accept = memory_writer_sink_valid && memory_writer_sink_ready;

  // A sop always restarts the frame at index 0; in IDLE only sop beats are taken.
  assign idx  = memory_writer_sink_sop ? '0 : cnt;
  assign take = accept && (memory_writer_sink_sop || (state == CAPTURE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                      <= IDLE;
      cnt                        <= '0;
      memory_writer_write        <= 1'b0;
      memory_writer_writeaddress <= '0;
      memory_writer_writedata    <= '0;
      memory_writer_trigger      <= 1'b0;
      memory_writer_error        <= 1'b0;
    end else begin
      state                      <= state_n;
      cnt                        <= cnt_n;
      memory_writer_write        <= write_n;
      memory_writer_writeaddress <= addr_n;
      memory_writer_writedata    <= data_n;
      memory_writer_trigger      <= trigger_n;
      // Set has priority over clear.
      if (err_set) begin
        memory_writer_error <= 1'b1;
      end else if (memory_writer_error_clear) begin
        memory_writer_error <= 1'b0;
      end
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    write_n   = 1'b0;
    addr_n    = memory_writer_writeaddress;
    data_n    = memory_writer_writedata;
    trigger_n = 1'b0;
    err_set   = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept && !memory_writer_sink_sop) begin
          err_set = 1'b1;
        end
      end
      CAPTURE: begin
        if (accept && memory_writer_sink_sop) begin
          err_set = 1'b1;
        end
      end
      DONE: begin
        trigger_n = 1'b1;
        state_n   = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (take) begin
      write_n = 1'b1;
      addr_n  = idx[ADDR_W-1:0];
      data_n  = memory_writer_sink_data;
      if (idx == LAST_IDX) begin
        state_n = DONE;
        cnt_n   = '0;
        if (!memory_writer_sink_eop) begin
          err_set = 1'b1;
        end
      end else if (memory_writer_sink_eop) begin
        state_n = IDLE;
        cnt_n   = '0;
        err_set = 1'b1;
      end else begin
        state_n = CAPTURE;
        cnt_n   = idx + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/memory_writer.md
MEMORY_WRITER -- requirements
Module: memory_writer

Interface
REQ-001 Parameter FRAME_LEN, default 8192, words per frame; SHALL be a power of two, 2..8192.
REQ-002 Parameter ADDR_W, default 13, memory word-address width; SHALL satisfy 2**ADDR_W >= FRAME_LEN.
REQ-003 clk  in  1  single clock; all logic SHALL be rising-edge.
REQ-004 rst  in  1  reset, asynchronous and active-high.
REQ-005 memory_writer_sink_data  in  32  sample word (Avalon-ST sink).
REQ-006 memory_writer_sink_valid / _sop / _eop  in  1 each  beat valid, start of packet, end of packet.
REQ-007 memory_writer_sink_ready  out  1  SHALL be 1 when a beat can be accepted.
REQ-008 memory_writer_writeaddress  out  ADDR_W  memory write address (Avalon-MM master).
REQ-009 memory_writer_write  out  1  write strobe, one word per asserted cycle.
REQ-010 memory_writer_writedata  out  32  write data.
REQ-011 memory_writer_trigger  out  1  one-cycle pulse: frame complete; drives the reader's trigger input.
REQ-012 memory_writer_error  out  1  sticky frame-format error flag.
REQ-013 memory_writer_error_clear  in  1  synchronous clear of the error flag.

Function
REQ-014 Accept: a beat SHALL be accepted exactly when sink_valid and sink_ready are both 1.
REQ-015 FSM states: IDLE, CAPTURE, DONE.
REQ-016 IDLE: sink_ready=1; accepting a beat with sop=1 SHALL write it to address 0, set counter=1, and go to CAPTURE; accepted beats with sop=0 SHALL be dropped and set error.
REQ-017 CAPTURE: sink_ready=1; each accepted beat SHALL be written to address counter, then counter increments.
REQ-018 Write latency: write, writeaddress and writedata SHALL be registered and assert the cycle after acceptance; write SHALL be 0 in any cycle with no accepted beat the previous cycle.
REQ-019 Completion: the accepted beat at index FRAME_LEN-1 SHALL be written and the FSM SHALL go to DONE, whether eop is 1 or 0. If eop is 0 at this beat, error SHALL be set.
REQ-020 Early eop: eop=1 at index < FRAME_LEN-1 SHALL write the beat, set error, and return to IDLE without a trigger.
REQ-021 sop=1 during CAPTURE SHALL restart the frame: write to address 0, counter=1, set error.
REQ-022 sop and eop both 1 on a beat SHALL be treated as sop, then the early-eop rule applies: the beat is written to address 0, error is set, and the FSM goes to IDLE when FRAME_LEN>1.
REQ-023 DONE: sink_ready=0 for exactly one cycle; trigger SHALL pulse 1 in the cycle after the final write strobe; the FSM then goes to IDLE.
REQ-024 Counter width SHALL be ADDR_W+1 bits; writeaddress SHALL be its low ADDR_W bits; the address SHALL never reach FRAME_LEN.
REQ-025 Error: set on any REQ-016/019/020/021 condition; error_clear SHALL clear it unless a set condition occurs the same cycle, in which case set wins.
REQ-026 A valid that is 0 SHALL not advance state or counter; gaps in the stream are legal.

Reset
REQ-027 On rst: state=IDLE, counter=0, write=0, writeaddress=0, writedata=0, trigger=0, error=0.
REQ-028 sink_ready SHALL be 0 while rst=1 and 1 from the first cycle after release.
REQ-029 Reset mid-frame SHALL abandon the frame: no trigger and no further writes; the next frame SHALL start at address 0.

Structure
REQ-030 The state_t enum and the default FRAME_LEN constant (8192) SHALL live in the shared DFT package, also used by the reader.
REQ-031 A single module with no sub-modules SHALL be used; the FSM and datapath stay inline.

Verification
REQ-032 FRAME_LEN=8: 8 beats with data 0x100..0x107, sop on the first and eop on the last, with valid gaps -> 8 writes to addresses 0..7 with matching data; trigger pulses once, one cycle after the last write; error=0.
REQ-033 FRAME_LEN=8: eop on the 4th beat -> addresses 0..3 are written; no trigger; error=1; a following good frame -> trigger pulses and error stays 1 until error_clear.
REQ-034 FRAME_LEN=8: a sop on the 5th beat, then 8 more beats -> 5th beat written to address 0; final frame writes 0..7; trigger pulses once; error=1.
REQ-035 Beats without sop in IDLE -> no writes, error=1; error_clear with no new error -> error=0 the next cycle.
REQ-036 Back-to-back frames with valid held at 1 -> ready=0 for exactly one cycle (DONE); second frame captured intact; two trigger pulses.
REQ-037 rst asserted after 3 beats -> outputs go to reset values immediately; no trigger; the next frame writes from address 0.
